branch_predictor: RTL and testbench

Parametrised branch target buffer (BTB) with per-entry saturating counters. It supplies the fetch stage with a same-cycle taken/target prediction for the current PC, and it is trained by branches resolved in EX. It generalises the core's fixed prediction path in three ways: configurable entry count, address width and counter width. It adds tag checking, bulk invalidation and optional statistics.

---
 rtl/branch_predictor.sv | 174 +++++++++++++++++
 tb/tb_branch_predictor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with per-entry saturating
//               counters. It gives a same-cycle taken/target prediction for
//               the fetch PC and is trained by resolved branches from EX.
//               Optional update/miss statistics: BRANCH_PREDICTOR_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              jump_pred,
    output logic [ADDR_W-1:0] jump_pred_adr,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_adr,
    output logic              upd_miss,
    input  logic              btb_clear,
    output logic [15:0]       stat_upd,
    output logic [15:0]       stat_miss
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [CTR_W-1:0] c_ctr_weak = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] c_ctr_max  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_ctr_min  = {CTR_W{1'b0}};

    // ------------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------------
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];

    // ------------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic              w_lk_hit;
    logic [ADDR_W-1:0] w_pc_inc;

    assign w_lk_idx = pc[IDX_W-1:0];
    assign w_lk_tag = pc[ADDR_W-1:IDX_W];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_pc_inc = pc + ADDR_W'(1);

    assign jump_pred     = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
    assign jump_pred_adr = jump_pred ? r_target[w_lk_idx] : w_pc_inc;

    // ------------------------------------------------------------------------
    // Resolution-side miss detection
    // ------------------------------------------------------------------------
    logic w_dir_miss;
    logic w_tgt_miss;

    assign w_dir_miss = (upd_taken != upd_pred_taken);
    assign w_tgt_miss = upd_taken && (upd_target != upd_pred_adr);
    assign upd_miss   = upd_en && (w_dir_miss || w_tgt_miss);

    // ------------------------------------------------------------------------
    // Training decode
    // ------------------------------------------------------------------------
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_up_ok;
    logic             w_wr_hit;
    logic             w_wr_alloc;
    logic [CTR_W-1:0] w_cur_ctr;
    logic [CTR_W-1:0] w_nxt_ctr;

    assign w_up_idx = upd_pc[IDX_W-1:0];
    assign w_up_tag = upd_pc[ADDR_W-1:IDX_W];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // A bulk clear drops any update issued in the same cycle.
    assign w_up_ok    = upd_en && !btb_clear;
    assign w_wr_hit   = w_up_ok && w_up_hit;
    assign w_wr_alloc = w_up_ok && !w_up_hit && upd_taken;

    assign w_cur_ctr = r_ctr[w_up_idx];

    always_comb begin
        w_nxt_ctr = w_cur_ctr;
        if (upd_taken) begin
            if (w_cur_ctr != c_ctr_max) begin
                w_nxt_ctr = w_cur_ctr + CTR_W'(1);
            end
        end else begin
            if (w_cur_ctr != c_ctr_min) begin
                w_nxt_ctr = w_cur_ctr - CTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Valid bits and counters (reset state)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_ctr_min;
            end
        end else if (btb_clear) begin
            r_valid <= '0;
        end else if (w_wr_hit) begin
            r_ctr[w_up_idx] <= w_nxt_ctr;
        end else if (w_wr_alloc) begin
            r_valid[w_up_idx] <= 1'b1;
            r_ctr[w_up_idx]   <= c_ctr_weak;
        end
    end

    // ------------------------------------------------------------------------
    // Tags and targets carry no reset; valid bits guard them.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_wr_alloc) begin
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= upd_target;
            end else if (w_wr_hit && upd_taken) begin
                r_target[w_up_idx] <= upd_target;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_STATS_EN
    localparam logic [15:0] c_stat_max = 16'hFFFF;

    logic [15:0] r_stat_upd;
    logic [15:0] r_stat_miss;

    // Counters keep running across btb_clear; only reset zeroes them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_upd  <= '0;
            r_stat_miss <= '0;
        end else begin
            if (upd_en && (r_stat_upd != c_stat_max)) begin
                r_stat_upd <= r_stat_upd + 16'd1;
            end
            if (upd_miss && (r_stat_miss != c_stat_max)) begin
                r_stat_miss <= r_stat_miss + 16'd1;
            end
        end
    end

    assign stat_upd  = r_stat_upd;
    assign stat_miss = r_stat_miss;
`else
    assign stat_upd  = 16'h0000;
    assign stat_miss = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor
//               (ADDR_W=16, ENTRIES=16, CTR_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic        jump_pred;
    logic [15:0] jump_pred_adr;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_pred_taken;
    logic [15:0] upd_pred_adr;
    logic        upd_miss;
    logic        btb_clear;
    logic [15:0] stat_upd;
    logic [15:0] stat_miss;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(
        .ADDR_W (16),
        .ENTRIES(16),
        .CTR_W  (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .jump_pred     (jump_pred),
        .jump_pred_adr (jump_pred_adr),
        .upd_en        (upd_en),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_pred_taken(upd_pred_taken),
        .upd_pred_adr  (upd_pred_adr),
        .upd_miss      (upd_miss),
        .btb_clear     (btb_clear),
        .stat_upd      (stat_upd),
        .stat_miss     (stat_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [15:0] a, input logic jp, input logic [15:0] adr);
        pc = a;
        #1;
        check({tag, ".jp"},  32'(jump_pred), 32'(jp));
        check({tag, ".adr"}, 32'(jump_pred_adr), 32'(adr));
    endtask

    // One-cycle update; the combinational miss flag is checked before the edge.
    task automatic upd(input string tag, input logic [15:0] a, input logic tk, input logic [15:0] tgt,
                       input logic ptk, input logic [15:0] padr, input logic exp_miss);
        upd_en         = 1'b1;
        upd_pc         = a;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_pred_taken = ptk;
        upd_pred_adr   = padr;
        #1;
        check({tag, ".miss"}, 32'(upd_miss), 32'(exp_miss));
        tick();
        upd_en = 1'b0;
    endtask

    logic [15:0] exp_su;
    logic [15:0] exp_sm;

    initial begin
        reset = 1'b1; pc = '0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_adr = '0; btb_clear = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // 1: reset state
        look("rst_0040", 16'h0040, 1'b0, 16'h0041);
        look("rst_ffff", 16'hFFFF, 1'b0, 16'h0000);
        check("rst_stat_upd",  32'(stat_upd),  32'h0);
        check("rst_stat_miss", 32'(stat_miss), 32'h0);
        upd_pred_taken = 1'b1; upd_taken = 1'b0; #1;
        check("miss_idle", 32'(upd_miss), 32'h0);

        // 2: allocate 0x0043 -> 0x0100
        upd("alloc", 16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0044, 1'b1);
        look("hit_0043", 16'h0043, 1'b1, 16'h0100);
        look("alias_0053", 16'h0053, 1'b0, 16'h0054);

        // 3: counter hysteresis (starts at weakly taken)
        upd("nt1", 16'h0043, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1);
        look("ctr01", 16'h0043, 1'b0, 16'h0044);
        upd("t1", 16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0044, 1'b1);
        upd("t2", 16'h0043, 1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0);
        upd("t3", 16'h0043, 1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0);
        look("ctr11", 16'h0043, 1'b1, 16'h0100);
        upd("nt2", 16'h0043, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1);
        look("ctr10_sat", 16'h0043, 1'b1, 16'h0100);
        upd("nt_unalloc", 16'h0077, 1'b0, 16'h0000, 1'b0, 16'h0078, 1'b0);
        look("unalloc_0077", 16'h0077, 1'b0, 16'h0078);
        // drive down past zero: 10 -> 01 -> 00 -> 00, then one taken -> 01
        upd("nt3", 16'h0043, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b0);
        upd("nt4", 16'h0043, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b0);
        upd("nt5", 16'h0043, 1'b0, 16'h0000, 1'b0, 16'h0044, 1'b0);
        upd("t4", 16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0044, 1'b1);
        look("ctr01_low", 16'h0043, 1'b0, 16'h0044);
        upd("t5", 16'h0043, 1'b1, 16'h0100, 1'b0, 16'h0044, 1'b1);
        look("ctr10_again", 16'h0043, 1'b1, 16'h0100);

        // 4: same-cycle lookup and update see old contents
        pc = 16'h0043; upd_en = 1'b1; upd_pc = 16'h0043; upd_taken = 1'b0;
        upd_pred_taken = 1'b1; upd_pred_adr = 16'h0100; #1;
        check("byp_old.jp",  32'(jump_pred), 32'h1);
        check("byp_old.adr", 32'(jump_pred_adr), 32'h0100);
        tick(); upd_en = 1'b0;
        look("byp_new", 16'h0043, 1'b0, 16'h0044);
        pc = 16'h0043; upd_en = 1'b1; upd_taken = 1'b1; upd_target = 16'h0200;
        upd_pred_taken = 1'b0; upd_pred_adr = 16'h0044; #1;
        check("tgt_old.jp",  32'(jump_pred), 32'h0);
        check("tgt_old.adr", 32'(jump_pred_adr), 32'h0044);
        tick(); upd_en = 1'b0;
        look("tgt_new", 16'h0043, 1'b1, 16'h0200);

        // 5: clear beats a same-cycle taken update
        btb_clear = 1'b1;
        upd("clr_upd", 16'h0045, 1'b1, 16'h0300, 1'b0, 16'h0046, 1'b1);
        btb_clear = 1'b0;
        look("clr_0043", 16'h0043, 1'b0, 16'h0044);
        look("clr_0045", 16'h0045, 1'b0, 16'h0046);

        // reset beats a same-cycle taken update
        reset = 1'b1;
        upd("rst_upd", 16'h0050, 1'b1, 16'h0400, 1'b0, 16'h0051, 1'b1);
        reset = 1'b0;
        look("rst_0050", 16'h0050, 1'b0, 16'h0051);
        check("rst2_stat_upd", 32'(stat_upd), 32'h0);

        // 6: statistics, five updates with two mispredictions
        upd("s1", 16'h0010, 1'b1, 16'h0100, 1'b1, 16'h0100, 1'b0);
        upd("s2", 16'h0011, 1'b0, 16'h0000, 1'b0, 16'h0012, 1'b0);
        upd("s3", 16'h0012, 1'b1, 16'h0100, 1'b0, 16'h0013, 1'b1);
        upd("s4", 16'h0013, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b1);
        upd("s5", 16'h0014, 1'b0, 16'h0000, 1'b0, 16'h0300, 1'b0);
`ifdef BRANCH_PREDICTOR_STATS_EN
        exp_su = 16'd5; exp_sm = 16'd2;
`else
        exp_su = 16'd0; exp_sm = 16'd0;
`endif
        check("stat_upd",  32'(stat_upd),  32'(exp_su));
        check("stat_miss", 32'(stat_miss), 32'(exp_sm));
        btb_clear = 1'b1; tick(); btb_clear = 1'b0;
        check("stat_upd_clr",  32'(stat_upd),  32'(exp_su));
        check("stat_miss_clr", 32'(stat_miss), 32'(exp_sm));
        look("s1_cleared", 16'h0010, 1'b0, 16'h0011);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
